tick_scheduler: RTL

TICK_SCHEDULER -- requirements
Module: tick_scheduler

---
 rtl/tick_scheduler_pkg.sv | 16 +
 rtl/tick_scheduler_if.sv | 29 ++
 rtl/tick_scheduler_prescaler.sv | 46 ++++
 rtl/tick_scheduler.sv | 122 ++++++++++++
 4 files changed

// File: rtl/tick_scheduler_pkg.sv
// Shared definitions for the tick scheduler: FSM state encoding, reset-time
// terminal count and tick-counter width.
package tick_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // 10 Hz tick from a 50 MHz clock: period is limit+1 cycles.
  localparam logic [31:0] DEF_LIMIT = 32'd4999999;

  localparam int TICK_CNT_W = 8;

endpackage

// File: rtl/tick_scheduler_if.sv
// Command and status bundle of the tick scheduler; the controller drives the
// i_* commands, the scheduler drives the o_* status.
interface tick_scheduler_if;
  import tick_scheduler_pkg::*;

  logic        i_start;
  logic        i_stop;
  logic        i_clear;
  logic        i_limit_wr;
  logic [31:0] i_limit;

  logic        o_tick;
  logic        o_sec_pulse;
  logic        o_running;
  state_e      o_state;
  logic        o_limit_err;
  logic [31:0] o_count;

  modport master (
    output i_start, i_stop, i_clear, i_limit_wr, i_limit,
    input  o_tick, o_sec_pulse, o_running, o_state, o_limit_err, o_count
  );

  modport slave (
    input  i_start, i_stop, i_clear, i_limit_wr, i_limit,
    output o_tick, o_sec_pulse, o_running, o_state, o_limit_err, o_count
  );

endinterface

// File: rtl/tick_scheduler_prescaler.sv
// Free-running 32-bit prescaler that wraps to zero after reaching i_limit.
// o_wrap flags, combinationally, that the coming edge performs the wrap.
module tick_prescaler
  import tick_scheduler_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_en,
  input  logic        i_load_zero,
  input  logic [31:0] i_limit,
  output logic [31:0] o_count,
  output logic        o_wrap
);

  logic [31:0] count_q;
  logic [31:0] count_d;
  logic        wrap;

  // A synchronous load-zero outranks counting, so it also swallows a wrap.
  always_comb begin
    count_d = count_q;
    wrap    = 1'b0;
    if (i_load_zero) begin
      count_d = 32'd0;
    end else if (i_en) begin
      if (count_q == i_limit) begin
        count_d = 32'd0;
        wrap    = 1'b1;
      end else begin
        count_d = count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;
  assign o_wrap  = wrap;

endmodule

// File: rtl/tick_scheduler.sv
// Run/pause/clear controller around the prescaler; owns the FSM, the
// per-second tick counter and the programmable terminal count.
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter logic [31:0] DEF_LIMIT     = tick_scheduler_pkg::DEF_LIMIT,
  parameter int unsigned TICKS_PER_SEC = 10
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  tick_scheduler_if.slave   bus
);

  localparam logic [TICK_CNT_W-1:0] TPS_LAST = TICK_CNT_W'(TICKS_PER_SEC - 1);

  state_e                  state_q;
  state_e                  state_d;
  logic [TICK_CNT_W-1:0]   tcnt_q;
  logic [TICK_CNT_W-1:0]   tcnt_d;
  logic [31:0]             limit_q;
  logic [31:0]             limit_d;
  logic                    tick_q;
  logic                    tick_d;
  logic                    sec_q;
  logic                    sec_d;
  logic                    running_q;
  logic                    running_d;
  logic                    err_q;
  logic                    err_d;

  logic                    do_clear;
  logic                    do_stop;
  logic                    do_start;
  logic                    pre_en;
  logic                    wrap;
  logic                    wr_ok;
  logic [31:0]             count;

  // Strict priority: a higher command masks lower ones even where it is a no-op.
  always_comb begin
    do_clear = bus.i_clear;
    do_stop  = !bus.i_clear && bus.i_stop;
    do_start = !bus.i_clear && !bus.i_stop && bus.i_start;

    state_d = state_q;
    if (do_clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (do_start) state_d = ST_RUN;
        ST_RUN:   if (do_stop)  state_d = ST_PAUSE;
        ST_PAUSE: if (do_start) state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
    running_d = (state_d == ST_RUN);
  end

  // A stop freezes the count on its own accepting edge, pre-empting a wrap.
  assign pre_en = (state_q == ST_RUN) && !do_stop;

  tick_prescaler u_prescaler (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_en        (pre_en),
    .i_load_zero (do_clear),
    .i_limit     (limit_q),
    .o_count     (count),
    .o_wrap      (wrap)
  );

  always_comb begin
    tcnt_d = tcnt_q;
    tick_d = wrap;
    sec_d  = 1'b0;
    if (do_clear) begin
      tcnt_d = '0;
    end else if (wrap) begin
      if (tcnt_q == TPS_LAST) begin
        tcnt_d = '0;
        sec_d  = 1'b1;
      end else begin
        tcnt_d = tcnt_q + TICK_CNT_W'(1);
      end
    end
  end

  // A clear in the same cycle puts the write in IDLE context.
  always_comb begin
    wr_ok   = bus.i_limit_wr && (do_clear || state_q == ST_IDLE) && (bus.i_limit != 32'd0);
    limit_d = wr_ok ? bus.i_limit : limit_q;
    err_d   = bus.i_limit_wr && !wr_ok;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= ST_IDLE;
      tcnt_q    <= '0;
      limit_q   <= DEF_LIMIT;
      tick_q    <= 1'b0;
      sec_q     <= 1'b0;
      running_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      limit_q   <= limit_d;
      tick_q    <= tick_d;
      sec_q     <= sec_d;
      running_q <= running_d;
      err_q     <= err_d;
    end
  end

  assign bus.o_tick      = tick_q;
  assign bus.o_sec_pulse = sec_q;
  assign bus.o_running   = running_q;
  assign bus.o_state     = state_q;
  assign bus.o_limit_err = err_q;
  assign bus.o_count     = count;

endmodule
